debounce_tick: RTL
==================

Name: debounce_tick

Overview:
- Conditions one raw, asynchronous push-button/switch input into a clean level plus single-cycle strobes.
- Sits directly upstream of the 1-bit enable registers: db_level drives their d, rise_tick/fall_tick drive their en.
- A bounce-free, one-clock-wide enable means one key press latches exactly once.
- Contains a 2-flop synchronizer, a 4-state debounce FSM and a stability counter.

Parameters:
- DB_CYCLES, 1000000, consecutive stable samples required before a level change is accepted (10 ms at 100 MHz); legal range 2 to 2^CNT_W-1.
- CNT_W, 20, width of the stability counter; must hold DB_CYCLES-1.
- REPEAT_CYCLES, 25000000, auto-repeat period in clocks. Used only with AUTOREPEAT_EN; must fit in 25 bits.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- sw, input, 1, raw asynchronous button/switch level; may bounce.
- db_level, output, 1, debounced level, registered.
- rise_tick, output, 1, one-cycle pulse when db_level goes 0->1, plus auto-repeats if enabled; registered.
- fall_tick, output, 1, one-cycle pulse when db_level goes 1->0; registered.

Behaviour:
- Reset, asynchronous: sync0=sync1=0, state=ZERO, cnt=0, db_level=0, rise_tick=0, fall_tick=0, repeat counter=0. Reset overrides all events, including mid-count.
- Synchronizer: sync0<=sw, sync1<=sync0. The FSM sees only sync1.
- FSM states and transitions:
  - ZERO: db_level=0. If sync1=1, go to WAIT1 and load cnt=DB_CYCLES-1.
  - WAIT1: if sync1=0, return to ZERO; no tick. Else if cnt!=0, decrement cnt. Else (cnt=0 and sync1=1), go to ONE, set db_level<=1, assert rise_tick for exactly that next cycle.
  - ONE: db_level=1. If sync1=0, go to WAIT0 and load cnt=DB_CYCLES-1.
  - WAIT0: mirror of WAIT1. If sync1=1, return to ONE. On expiry with sync1=0, go to ZERO, set db_level<=0, pulse fall_tick.
- Ticks are high for exactly one clock and are never asserted simultaneously.
- A bounce during WAITx aborts the count. The next attempt restarts from DB_CYCLES-1; there is no accumulation across aborts.
- Latency: sw first sampled high at edge k and held high gives db_level=1 and rise_tick=1 after edge k+DB_CYCLES+2. Release latency is identical.
- Reset released while sw is held high: treated as a new press. A full debounce runs, then rise_tick fires once.
- Counter never wraps. It is loaded only on entry to WAITx and decremented only while nonzero.
- Outputs are pure flops; there is no combinational path from sw.

Optional Feature:
- Macro: DEBOUNCE_TICK_AUTOREPEAT_EN.
- Defined:
  - While in ONE, a 25-bit repeat counter counts up from 0 (cleared on entry to ONE).
  - On reaching REPEAT_CYCLES-1 it clears and pulses rise_tick for one cycle; this repeats for as long as the state stays ONE.
  - Leaving ONE clears the counter and does not emit a pending repeat tick.
- Undefined: the counter logic is absent, and rise_tick fires exactly once per accepted press.

Test Plan (DB_CYCLES=4, CNT_W=3, REPEAT_CYCLES=8):
- Reset asserted mid-WAIT1 with sw=1 -> all outputs 0 immediately. After release with sw still 1, rise_tick fires once, 6 cycles later.
- Clean press: sw 0->1 sampled at edge 10 -> db_level=1 and rise_tick=1 after edge 16; rise_tick=0 after edge 17; no further ticks while held.
- Bounce: sw pattern 1,0,1,1,0,1 then steady 1 -> no tick during the bounce; a single rise_tick 6 cycles after the last 0->1 sample.
- Clean release after a press: sw 1->0 -> fall_tick one cycle wide 6 cycles later; db_level=0; rise_tick stays 0.
- Glitch shorter than DB_CYCLES (sw=1 for 3 samples) -> db_level stays 0; no ticks.
- With DEBOUNCE_TICK_AUTOREPEAT_EN, holding sw=1 for 40 cycles after acceptance -> rise_tick at acceptance, then every 8 cycles; no tick after release begins.

Source files
------------

// File: rtl/debounce_tick_if.sv
// Button conditioner signal bundle: raw switch in, clean level and strobes out.
interface debounce_tick_if;
    logic sw;
    logic db_level;
    logic rise_tick;
    logic fall_tick;

    modport master (
        output sw,
        input  db_level,
        input  rise_tick,
        input  fall_tick
    );

    modport slave (
        input  sw,
        output db_level,
        output rise_tick,
        output fall_tick
    );
endinterface

// File: rtl/debounce_tick.sv
// Debounces one raw switch into a registered level plus one-cycle edge ticks.
// Optional auto-repeat of rise_tick while held: DEBOUNCE_TICK_AUTOREPEAT_EN.
module debounce_tick #(
    parameter int DB_CYCLES     = 1000000,
    parameter int CNT_W         = 20,
    parameter int REPEAT_CYCLES = 25000000
) (
    input  logic           clk,
    input  logic           reset,
    debounce_tick_if.slave bus
);
    localparam logic [1:0] ZERO  = 2'd0;
    localparam logic [1:0] WAIT1 = 2'd1;
    localparam logic [1:0] ONE   = 2'd2;
    localparam logic [1:0] WAIT0 = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);

    logic             sync0_q, sync0_d;
    logic             sync1_q, sync1_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

`ifdef DEBOUNCE_TICK_AUTOREPEAT_EN
    localparam logic [24:0] REP_LAST = 25'(REPEAT_CYCLES - 1);
    logic [24:0] rep_q, rep_d;
`endif

    always_comb begin
        sync0_d = bus.sw;
        sync1_d = sync0_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ZERO: begin
                if (sync1_q) begin
                    state_d = WAIT1;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!sync1_q) begin
                    state_d = ZERO;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ONE;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end
            end
            ONE: begin
                if (!sync1_q) begin
                    state_d = WAIT0;
                    cnt_d   = CNT_LOAD;
                end
            end
            default: begin
                if (sync1_q) begin
                    state_d = ONE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ZERO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end
            end
        endcase
    end

`ifdef DEBOUNCE_TICK_AUTOREPEAT_EN
    // Runs only while resting in ONE; any exit or re-entry restarts it.
    always_comb begin
        rep_d = '0;
        if (state_q == ONE && sync1_q) begin
            if (rep_q != REP_LAST) begin
                rep_d = rep_q + 25'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end

    wire rep_fire = (state_q == ONE) && sync1_q && (rep_q == REP_LAST);
`else
    wire rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            state_q <= ZERO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d | rep_fire;
            fall_q  <= fall_d;
        end
    end

    assign bus.db_level  = level_q;
    assign bus.rise_tick = rise_q;
    assign bus.fall_tick = fall_q;
endmodule
